// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: a direct-mapped BTB with 2-bit saturating
// counters, execute-stage training, a registered mispredict redirect and
// saturating branch/mispredict statistics.
module branch_predictor #(
   parameter int unsigned PC_W    = 32,
   parameter int unsigned ENTRIES = 64,
   parameter int unsigned CNT_W   = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [PC_W-1:0]   fetch_pc,
   output logic              pred_taken,
   output logic [PC_W-1:0]   pred_target,
   input  logic              upd_valid,
   input  logic [PC_W-1:0]   upd_pc,
   input  logic [2:0]        upd_type,
   input  logic              upd_taken,
   input  logic [PC_W-1:0]   upd_target,
   input  logic [PC_W-1:0]   upd_pred_target,
   output logic              mispredict,
   output logic [PC_W-1:0]   redirect_pc,
   output logic [CNT_W-1:0]  br_count,
   output logic [CNT_W-1:0]  mp_count
);

   localparam int unsigned IDX_W = $clog2(ENTRIES);
   localparam int unsigned TAG_W = PC_W - IDX_W - 2;

   localparam logic [2:0] TYPE_NEVER  = 3'd2;
   localparam logic [2:0] TYPE_ALWAYS = 3'd3;

   // BTB storage
   logic             r_valid  [ENTRIES];
   logic [TAG_W-1:0] r_tag    [ENTRIES];
   logic [PC_W-1:0]  r_target [ENTRIES];
   logic [1:0]       r_ctr    [ENTRIES];

   logic             r_mispredict;
   logic [PC_W-1:0]  r_redirect_pc;
   logic [CNT_W-1:0] r_br_count;
   logic [CNT_W-1:0] r_mp_count;

   logic [IDX_W-1:0] w_f_idx;
   logic [TAG_W-1:0] w_f_tag;
   logic             w_f_hit;
   logic             w_pred_taken;

   logic [IDX_W-1:0] w_u_idx;
   logic [TAG_W-1:0] w_u_tag;
   logic             w_u_hit;
   logic             w_is_jump;
   logic             w_is_cond;
   logic             w_taken_eff;
   logic [PC_W-1:0]  w_actual;
   logic             w_mp;
   logic             w_count_br;

   logic             w_wr_en;
   logic [1:0]       w_wr_ctr;
   logic [PC_W-1:0]  w_wr_target;

   // Zero-latency lookup; sees pre-edge table state (no update bypass)
   assign w_f_idx      = fetch_pc[IDX_W+1:2];
   assign w_f_tag      = fetch_pc[PC_W-1:IDX_W+2];
   assign w_f_hit      = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
   assign w_pred_taken = w_f_hit && r_ctr[w_f_idx][1];
   assign pred_taken   = w_pred_taken;
   assign pred_target  = w_pred_taken ? r_target[w_f_idx] : fetch_pc + PC_W'(4);

   // Resolution: effective outcome, correct next PC and mispredict condition
   assign w_u_idx     = upd_pc[IDX_W+1:2];
   assign w_u_tag     = upd_pc[PC_W-1:IDX_W+2];
   assign w_u_hit     = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);
   assign w_is_jump   = (upd_type == TYPE_ALWAYS);
   assign w_is_cond   = (upd_type != TYPE_ALWAYS) && (upd_type != TYPE_NEVER);
   assign w_taken_eff = w_is_jump || (w_is_cond && upd_taken);
   assign w_actual    = w_taken_eff ? upd_target : upd_pc + PC_W'(4);
   assign w_mp        = upd_valid && (w_actual != upd_pred_target);
   assign w_count_br  = upd_valid && (upd_type != TYPE_NEVER);

   // Training decision: which entry fields change on this update
   always_comb begin
      w_wr_en     = 1'b0;
      w_wr_ctr    = r_ctr[w_u_idx];
      w_wr_target = r_target[w_u_idx];
      if (upd_valid) begin
         if (w_is_jump) begin
            w_wr_en     = 1'b1;
            w_wr_ctr    = 2'b11;
            w_wr_target = upd_target;
         end else if (w_is_cond) begin
            if (w_u_hit) begin
               w_wr_en = 1'b1;
               if (upd_taken) begin
                  w_wr_ctr    = (r_ctr[w_u_idx] == 2'b11) ? 2'b11 : r_ctr[w_u_idx] + 2'd1;
                  w_wr_target = upd_target;
               end else begin
                  w_wr_ctr    = (r_ctr[w_u_idx] == 2'b00) ? 2'b00 : r_ctr[w_u_idx] - 2'd1;
               end
            end else if (upd_taken) begin
               w_wr_en     = 1'b1;
               w_wr_ctr    = 2'b10;
               w_wr_target = upd_target;
            end
         end
      end
   end

   // BTB write port; reset invalidates every entry and sets weak-not-taken
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(ENTRIES); i++) begin
            r_valid[i]  <= 1'b0;
            r_tag[i]    <= '0;
            r_target[i] <= '0;
            r_ctr[i]    <= 2'b01;
         end
      end else if (w_wr_en) begin
         r_valid[w_u_idx]  <= 1'b1;
         r_tag[w_u_idx]    <= w_u_tag;
         r_target[w_u_idx] <= w_wr_target;
         r_ctr[w_u_idx]    <= w_wr_ctr;
      end
   end

   // Registered redirect pulse and saturating statistics
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mispredict  <= 1'b0;
         r_redirect_pc <= '0;
         r_br_count    <= '0;
         r_mp_count    <= '0;
      end else begin
         r_mispredict <= w_mp;
         if (upd_valid) begin
            r_redirect_pc <= w_actual;
         end
         if (w_count_br && (r_br_count != '1)) begin
            r_br_count <= r_br_count + CNT_W'(1);
         end
         if (w_count_br && w_mp && (r_mp_count != '1)) begin
            r_mp_count <= r_mp_count + CNT_W'(1);
         end
      end
   end

   assign mispredict  = r_mispredict;
   assign redirect_pc = r_redirect_pc;
   assign br_count    = r_br_count;
   assign mp_count    = r_mp_count;

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side branch predictor and resolution checker for the pipelined core; it is the counterpart of the execute-stage branch condition unit.
- Fetch queries a direct-mapped BTB with 2-bit saturating counters and gets a predicted next PC.
- Execute later returns the resolved branch_taken outcome and the original prediction.
- The block trains the table, flags mispredictions with a registered redirect, and keeps branch/mispredict statistics.

Parameters:
- PC_W, 32, program counter width.
- ENTRIES, 64, BTB entries; power of 2, minimum 4.
- CNT_W, 32, width of the statistics counters.
- Derived, not overridable: IDX_W = log2(ENTRIES); TAG_W = PC_W - IDX_W - 2.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- fetch_pc  in  PC_W  PC being fetched.
- pred_taken  out  1  prediction for fetch_pc (combinational).
- pred_target  out  PC_W  predicted next PC (combinational).
- upd_valid  in  1  a resolved instruction is presented this cycle.
- upd_pc  in  PC_W  PC of the resolved instruction.
- upd_type  in  3  branch type, same encoding as the branch condition unit: 0 beq, 1 bne, 4 blt, 5 bge, 6 bltu, 7 bgeu, 2 never, 3 always (jump).
- upd_taken  in  1  resolved branch_taken.
- upd_target  in  PC_W  resolved taken target.
- upd_pred_target  in  PC_W  next PC that was predicted for this instruction.
- mispredict  out  1  registered one-cycle flush pulse.
- redirect_pc  out  PC_W  registered correct next PC; valid when mispredict=1.
- br_count  out  CNT_W  resolved branches, saturating.
- mp_count  out  CNT_W  mispredicted branches, saturating.

Behaviour:
- Reset: asynchronous on rst_n=0; only one clock domain.
  - All entries: valid=0, counter=2'b01.
  - mispredict=0, redirect_pc=0, br_count=0, mp_count=0.
  - Reset asserted mid-operation discards any in-flight update; there is no partial write.
- Addressing: idx = pc[IDX_W+1:2]; tag = pc[PC_W-1:IDX_W+2].
- Entry contents: valid, tag, target[PC_W], ctr[2].
  - Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Lookup (combinational, zero latency):
  - hit = valid && tag match.
  - pred_taken = hit && ctr[1].
  - pred_target = pred_taken ? target : fetch_pc+4, computed modulo 2^PC_W.
- Same-cycle update and lookup to the same index: the lookup sees pre-edge state; there is no bypass.
- Update (on the clock edge when upd_valid=1), by upd_type:
  - Conditional types 0,1,4-7, on a hit:
    - taken: ctr increments, saturating at 11; target <= upd_target.
    - not taken: ctr decrements, saturating at 00; target is unchanged.
  - Conditional types, on a miss:
    - taken: allocate/replace the entry with valid=1, new tag, target, ctr=10.
    - not taken: no write.
  - Type 3: allocate or overwrite with ctr=11 and target=upd_target; upd_taken is ignored and treated as 1.
  - Type 2: no table write; treated as not taken.
- Resolution check, registered with 1-cycle latency after the upd_valid edge:
  - actual = (taken_eff) ? upd_target : upd_pc+4.
  - mispredict <= upd_valid && (actual != upd_pred_target).
  - redirect_pc <= actual on upd_valid; it holds its value otherwise.
  - When upd_valid=0, mispredict <= 0.
- Statistics:
  - br_count increments on upd_valid && upd_type != 2.
  - mp_count increments when that condition holds and the mispredict condition is true, in the same edge as the mispredict register.
  - Both counters saturate at all-ones; no wrap.
- Undefined types: none exist; all 8 codes are covered.

Test Plan:
- Reset, then fetch_pc=0x100: pred_taken=0, pred_target=0x104; br_count=0, mp_count=0.
- upd beq pc=0x100, taken=1, target=0x200, pred_target=0x104:
  - Next cycle: mispredict=1, redirect_pc=0x200, mp_count=1.
  - fetch_pc=0x100 then gives pred_taken=1, pred_target=0x200 (ctr=10).
- Train the same branch taken 3 more times, then not-taken once:
  - Counter saturates at 11, then drops to 10; the prediction stays taken.
  - The not-taken update gives mispredict=1, redirect_pc=0x104.
- Aliasing, ENTRIES=64: pc=0x100 (taken) and pc=0x200 share idx 0 with different tags.
  - A taken update at 0x200 replaces the entry.
  - A lookup at 0x100 then misses: pred_target=0x104.
- Jump type 3 at pc=0x300, target=0x40 with pred_target=0x40: mispredict=0, entry ctr=11. A type-2 update leaves br_count unchanged and the table unchanged.
- Force br_count to all-ones, then apply an update: br_count holds its value. Asserting rst_n=0 between clock edges clears all outputs immediately.
